inst_seq: RTL and testbench
===========================

# inst_seq

Multi-cycle instruction sequencer for the NPC core. It owns the PC and steps each instruction through fetch, decode/execute, optional memory read and writeback. It drives the instruction word into the decoder and gates register-file writes. It stops simulation cleanly on the decoder's stop request or on a bus timeout.

## Interface
Parameters:
- RESET_PC, 32'h8000_0000, PC value after reset
- TIMEOUT, 255, max consecutive stalled cycles in any wait state before bus error (1..255)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- if_req_valid  out  1  fetch request
- if_req_ready  in  1  fetch request accepted
- if_addr  out  32  fetch address (= pc)
- if_rsp_valid  in  1  fetch response valid
- if_rsp_inst  in  32  fetched instruction
- inst  out  32  latched instruction to decoder
- dec_stop_sim  in  1  decoder stop request (ebreak / illegal)
- dec_memtoreg  in  1  instruction reads memory
- dec_rd  in  5  destination register
- alu_result  in  32  ALU output (write data or load address)
- br_taken  in  1  redirect PC
- br_target  in  32  redirect target
- mem_req_valid  out  1  load request
- mem_req_ready  in  1  load request accepted
- mem_addr  out  32  load address
- mem_rsp_valid  in  1  load data valid
- mem_rsp_rdata  in  32  load data
- rf_wen  out  1  register write strobe
- rf_waddr  out  5  write register
- rf_wdata  out  32  write data
- pc  out  32  current PC
- retired  out  1  one-cycle pulse per completed instruction
- halted  out  1  sequencer stopped
- bus_err  out  1  halt was caused by timeout

## Operation
- States are FETCH, IF_WAIT, EX, MEM, MEM_WAIT, WB and HALT. Reset state is FETCH.
- FETCH: if_req_valid=1 and if_addr=pc. On if_req_ready, go to IF_WAIT.
- IF_WAIT: on if_rsp_valid, latch if_rsp_inst into inst and go to EX. Responses in any other state are ignored.
- EX: the decoder sees the latched inst, and its outputs are sampled this cycle.
  - dec_stop_sim=1: go to HALT and pulse retired. No writeback; pc is unchanged.
  - Otherwise latch alu_result, dec_rd, dec_memtoreg, br_taken and br_target.
  - Then go to MEM if dec_memtoreg=1, else go to WB.
- MEM: mem_req_valid=1 and mem_addr = latched alu_result. On mem_req_ready, go to MEM_WAIT.
- MEM_WAIT: on mem_rsp_valid, latch mem_rsp_rdata and go to WB.
- WB:
  - rf_wen=1 unless the latched rd==0.
  - rf_waddr = latched rd.
  - rf_wdata = latched rdata if memtoreg, else latched ALU result.
  - pc <= br_taken ? br_target : pc+4 (mod 2^32).
  - Pulse retired and go to FETCH.
- HALT: absorbing state. Only reset exits it. halted=1, and all request and write outputs are 0.
- Timeout:
  - An 8-bit stall counter increments on each cycle in FETCH, IF_WAIT, MEM or MEM_WAIT where the exit condition is false.
  - It clears on every state change.
  - A stalled cycle with counter == TIMEOUT-1 goes to HALT with bus_err=1.
  - If the exit condition and the timeout coincide, the exit wins.
- Reset values:
  - pc=RESET_PC.
  - inst=32'h0000_0013 (nop).
  - Latched ALU result, rdata and rd are 0.
  - Stall counter is 0.
  - rf_wen, mem_req_valid, retired, halted and bus_err are 0.
  - if_req_valid=1, since the state is FETCH.
- Asserting rst_n low mid-instruction aborts immediately: no write and no retire. Outstanding bus responses after release are ignored until the next request is issued.

## Timing
- All state, pc and latches update on the rising edge of clk.
- Request, write and status outputs decode from registered state only; there are no combinational paths from inputs to outputs.
- ALU instruction with ready and response each in their first cycle takes 4 cycles: FETCH, IF_WAIT, EX, WB.
- Load instruction under the same conditions takes 6 cycles: adds MEM and MEM_WAIT.
- Each wait cycle on a handshake adds exactly one cycle.
- retired and rf_wen are high for exactly one cycle per instruction.
- pc changes only on the WB to FETCH edge.

## Test plan
- Reset with rst_n=0, then release → pc=32'h8000_0000, if_req_valid=1, halted=0. Then 4 addi with zero-wait bus → 4 retired pulses 4 cycles apart; pc=32'h8000_0010.
- addi x5 with alu_result=32'h0000_0007 → rf_wen=1, rf_waddr=5, rf_wdata=7 in WB. Same with rd=0 → rf_wen=0, but retired still pulses.
- Load with alu_result=32'h8000_0100, mem_rsp after 3 wait cycles, rdata=32'hDEAD_BEEF → mem_addr=32'h8000_0100; rf_wdata=32'hDEAD_BEEF; 9 cycles total.
- br_taken=1, br_target=32'h8000_0040 → next if_addr=32'h8000_0040.
- dec_stop_sim=1 in EX → retired pulse, then halted=1, bus_err=0, no rf_wen. Holds for 100 cycles.
- if_req_ready held 0 with TIMEOUT=4 → halted=1 and bus_err=1 on the 4th stalled cycle. Repeat with ready arriving on the 4th stalled cycle → no error. Then assert rst_n low mid-MEM_WAIT → outputs return to reset values without delay.

Source files
------------

// File: rtl/inst_seq.sv
// Multi-cycle instruction sequencer: owns the PC and steps each instruction
// through fetch, execute, optional load and writeback, with a bus-stall timeout.
module inst_seq #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int          TIMEOUT  = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        if_req_valid,
   input  logic        if_req_ready,
   output logic [31:0] if_addr,
   input  logic        if_rsp_valid,
   input  logic [31:0] if_rsp_inst,
   output logic [31:0] inst,
   input  logic        dec_stop_sim,
   input  logic        dec_memtoreg,
   input  logic [4:0]  dec_rd,
   input  logic [31:0] alu_result,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_addr,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_rdata,
   output logic        rf_wen,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic [31:0] pc,
   output logic        retired,
   output logic        halted,
   output logic        bus_err
);

   typedef enum logic [2:0] {
      S_FETCH, S_IF_WAIT, S_EX, S_MEM, S_MEM_WAIT, S_WB, S_HALT
   } state_t;

   localparam logic [7:0] STALL_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] alu_q, alu_d;
   logic [31:0] rdata_q, rdata_d;
   logic [4:0]  rd_q, rd_d;
   logic        memtoreg_q, memtoreg_d;
   logic        br_taken_q, br_taken_d;
   logic [31:0] br_target_q, br_target_d;
   logic [7:0]  stall_q, stall_d;
   logic        bus_err_q, bus_err_d;
   logic        stop_ret_q, stop_ret_d;
   logic        stalled;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_FETCH;
         pc_q        <= RESET_PC;
         inst_q      <= 32'h0000_0013;
         alu_q       <= '0;
         rdata_q     <= '0;
         rd_q        <= '0;
         memtoreg_q  <= 1'b0;
         br_taken_q  <= 1'b0;
         br_target_q <= '0;
         stall_q     <= '0;
         bus_err_q   <= 1'b0;
         stop_ret_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         inst_q      <= inst_d;
         alu_q       <= alu_d;
         rdata_q     <= rdata_d;
         rd_q        <= rd_d;
         memtoreg_q  <= memtoreg_d;
         br_taken_q  <= br_taken_d;
         br_target_q <= br_target_d;
         stall_q     <= stall_d;
         bus_err_q   <= bus_err_d;
         stop_ret_q  <= stop_ret_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      inst_d      = inst_q;
      alu_d       = alu_q;
      rdata_d     = rdata_q;
      rd_d        = rd_q;
      memtoreg_d  = memtoreg_q;
      br_taken_d  = br_taken_q;
      br_target_d = br_target_q;
      bus_err_d   = bus_err_q;
      stop_ret_d  = 1'b0;
      stall_d     = '0;
      stalled     = 1'b0;

      case (state_q)
         S_FETCH: begin
            if (if_req_ready) state_d = S_IF_WAIT;
            else              stalled = 1'b1;
         end
         S_IF_WAIT: begin
            if (if_rsp_valid) begin
               inst_d  = if_rsp_inst;
               state_d = S_EX;
            end else begin
               stalled = 1'b1;
            end
         end
         S_EX: begin
            if (dec_stop_sim) begin
               state_d    = S_HALT;
               stop_ret_d = 1'b1;
            end else begin
               alu_d       = alu_result;
               rd_d        = dec_rd;
               memtoreg_d  = dec_memtoreg;
               br_taken_d  = br_taken;
               br_target_d = br_target;
               state_d     = dec_memtoreg ? S_MEM : S_WB;
            end
         end
         S_MEM: begin
            if (mem_req_ready) state_d = S_MEM_WAIT;
            else               stalled = 1'b1;
         end
         S_MEM_WAIT: begin
            if (mem_rsp_valid) begin
               rdata_d = mem_rsp_rdata;
               state_d = S_WB;
            end else begin
               stalled = 1'b1;
            end
         end
         S_WB: begin
            pc_d    = br_taken_q ? br_target_q : pc_q + 32'd4;
            state_d = S_FETCH;
         end
         default: state_d = S_HALT;
      endcase

      // Counter only survives cycles that stay in the same wait state.
      if (stalled) begin
         if (stall_q == STALL_LAST) begin
            state_d   = S_HALT;
            bus_err_d = 1'b1;
         end else begin
            stall_d = stall_q + 8'd1;
         end
      end
   end

   assign if_req_valid  = (state_q == S_FETCH);
   assign if_addr       = pc_q;
   assign inst          = inst_q;
   assign mem_req_valid = (state_q == S_MEM);
   assign mem_addr      = alu_q;
   assign rf_wen        = (state_q == S_WB) && (rd_q != 5'd0);
   assign rf_waddr      = rd_q;
   assign rf_wdata      = memtoreg_q ? rdata_q : alu_q;
   assign pc            = pc_q;
   // A stop retires in the first HALT cycle so the pulse stays register-driven.
   assign retired       = (state_q == S_WB) || stop_ret_q;
   assign halted        = (state_q == S_HALT);
   assign bus_err       = bus_err_q;

endmodule

// File: tb/tb_inst_seq.sv
// Self-checking bench for inst_seq: directed vector table, randomized instruction
// stream against a behavioural model, halt, timeout and mid-instruction reset.
module tb_inst_seq;
   localparam logic [31:0] RPC = 32'h8000_0000;

   logic        clk, rst_n;
   logic        if_req_valid, if_req_ready, if_rsp_valid;
   logic [31:0] if_addr, if_rsp_inst, inst;
   logic        dec_stop_sim, dec_memtoreg, br_taken;
   logic [4:0]  dec_rd;
   logic [31:0] alu_result, br_target;
   logic        mem_req_valid, mem_req_ready, mem_rsp_valid;
   logic [31:0] mem_addr, mem_rsp_rdata;
   logic        rf_wen, retired, halted, bus_err;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata, pc;

   inst_seq #(.RESET_PC(RPC), .TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
      .if_rsp_valid(if_rsp_valid), .if_rsp_inst(if_rsp_inst), .inst(inst),
      .dec_stop_sim(dec_stop_sim), .dec_memtoreg(dec_memtoreg), .dec_rd(dec_rd),
      .alu_result(alu_result), .br_taken(br_taken), .br_target(br_target),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
      .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pc(pc),
      .retired(retired), .halted(halted), .bus_err(bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic [31:0] word;
      logic        load;
      logic [4:0]  rd;
      logic [31:0] alu;
      logic        br;
      logic [31:0] tgt;
      logic [31:0] rdata;
      logic        stop;
      int          if_stall;
      int          mem_stall;
   } instr_t;

   typedef struct {
      instr_t      in;
      int          cyc;
      logic        wen;
      logic [31:0] wdata;
      logic [31:0] pc_after;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   function automatic instr_t mk(input logic [31:0] word, input logic load, input logic [4:0] rd,
                                 input logic [31:0] alu, input logic br, input logic [31:0] tgt,
                                 input logic [31:0] rdata, input int if_stall, input int mem_stall);
      instr_t t;
      t.word = word; t.load = load; t.rd = rd; t.alu = alu; t.br = br; t.tgt = tgt;
      t.rdata = rdata; t.stop = 1'b0; t.if_stall = if_stall; t.mem_stall = mem_stall;
      return t;
   endfunction

   task automatic clear_inputs();
      if_req_ready = 0; if_rsp_valid = 0; if_rsp_inst = 0;
      dec_stop_sim = 0; dec_memtoreg = 0; dec_rd = 0; alu_result = 0;
      br_taken = 0; br_target = 0;
      mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Acts as bus and decoder for one instruction; starts in FETCH, returns on
   // the cycle after the retire pulse (or after a cycle budget).
   task automatic run_instr(input instr_t t, output int cycles, output int wen_cnt,
                            output logic [4:0] waddr, output logic [31:0] wdata,
                            output int ret_cnt, output logic [31:0] ifa, output logic [31:0] mema);
      int ph, scnt, mcnt;
      bit done;
      ph = 0; scnt = 0; mcnt = 0; done = 0;
      cycles = 0; wen_cnt = 0; ret_cnt = 0; waddr = 0; wdata = 0; ifa = 0; mema = 0;
      dec_stop_sim = t.stop; dec_memtoreg = t.load; dec_rd = t.rd;
      alu_result = t.alu; br_taken = t.br; br_target = t.tgt;
      while (!done && cycles < 60) begin
         cycles++;
         if_req_ready = 0; if_rsp_valid = 0; mem_req_ready = 0; mem_rsp_valid = 0;
         if (if_req_valid) begin
            ifa = if_addr;
            if (scnt >= t.if_stall) begin if_req_ready = 1; ph = 1; end
            else scnt++;
         end else if (ph == 1) begin
            if_rsp_valid = 1; if_rsp_inst = t.word; ph = 2;
         end
         if (mem_req_valid) begin
            mema = mem_addr; mem_req_ready = 1; ph = 3;
         end else if (ph == 3) begin
            if (mcnt >= t.mem_stall) begin mem_rsp_valid = 1; mem_rsp_rdata = t.rdata; ph = 2; end
            else mcnt++;
         end
         if (rf_wen) begin wen_cnt++; waddr = rf_waddr; wdata = rf_wdata; end
         if (retired) begin ret_cnt++; done = 1; end
         step();
      end
      clear_inputs();
   endtask

   task automatic check_instr(input string tag, input instr_t t, input logic [31:0] pc_before,
                              input int exp_cyc, input logic exp_wen, input logic [31:0] exp_wdata,
                              input logic [31:0] exp_pc);
      int cyc, wen_cnt, ret_cnt;
      logic [4:0] waddr;
      logic [31:0] wdata, ifa, mema;
      run_instr(t, cyc, wen_cnt, waddr, wdata, ret_cnt, ifa, mema);
      $display("%s: word=%h rd=%0d load=%0b br=%0b cycles=%0d wen=%0d wdata=%h pc=%h",
               tag, t.word, t.rd, t.load, t.br, cyc, wen_cnt, wdata, pc);
      chk({tag, "_cycles"}, cyc, exp_cyc);
      chk({tag, "_retired"}, ret_cnt, 1);
      chk({tag, "_if_addr"}, ifa, pc_before);
      chk({tag, "_wen_count"}, wen_cnt, exp_wen ? 1 : 0);
      if (exp_wen) begin
         chk({tag, "_waddr"}, {27'd0, waddr}, {27'd0, t.rd});
         chk({tag, "_wdata"}, wdata, exp_wdata);
      end
      if (t.load) chk({tag, "_mem_addr"}, mema, t.alu);
      chk({tag, "_pc"}, pc, exp_pc);
      chk({tag, "_inst"}, inst, t.word);
   endtask

   // Reference model: instruction effects from the architectural rules.
   task automatic model(input instr_t t, input logic [31:0] pc_before, output int cyc,
                        output logic wen, output logic [31:0] wdata, output logic [31:0] pc_after);
      cyc      = 4 + t.if_stall + ((!t.stop && t.load) ? 2 + t.mem_stall : 0);
      wen      = !t.stop && (t.rd != 5'd0);
      wdata    = t.load ? t.rdata : t.alu;
      pc_after = t.stop ? pc_before : (t.br ? t.tgt : pc_before + 32'd4);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step(); step();
      rst_n = 1'b1;
   endtask

   vec_t tbl[10];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      instr_t t;
      logic [31:0] mpc, wd, pa;
      logic wen;
      int cyc, bad;

      tbl[0] = '{mk(32'h0010_0093, 0, 5'd1, 32'd1, 0, 0, 0, 0, 0), 4, 1, 32'd1, 32'h8000_0004};
      tbl[1] = '{mk(32'h0020_0113, 0, 5'd2, 32'd2, 0, 0, 0, 0, 0), 4, 1, 32'd2, 32'h8000_0008};
      tbl[2] = '{mk(32'h0030_0193, 0, 5'd3, 32'd3, 0, 0, 0, 0, 0), 4, 1, 32'd3, 32'h8000_000C};
      tbl[3] = '{mk(32'h0040_0213, 0, 5'd4, 32'd4, 0, 0, 0, 0, 0), 4, 1, 32'd4, 32'h8000_0010};
      tbl[4] = '{mk(32'h0070_0293, 0, 5'd5, 32'd7, 0, 0, 0, 0, 0), 4, 1, 32'd7, 32'h8000_0014};
      tbl[5] = '{mk(32'h0090_0013, 0, 5'd0, 32'd9, 0, 0, 0, 0, 0), 4, 0, 32'd9, 32'h8000_0018};
      tbl[6] = '{mk(32'h0000_2303, 1, 5'd6, 32'h8000_0100, 0, 0, 32'hDEAD_BEEF, 0, 3),
                 9, 1, 32'hDEAD_BEEF, 32'h8000_001C};
      tbl[7] = '{mk(32'h0200_0393, 0, 5'd7, 32'h20, 1, 32'h8000_0040, 0, 0, 0),
                 4, 1, 32'h20, 32'h8000_0040};
      tbl[8] = '{mk(32'h0550_0413, 0, 5'd8, 32'h55, 0, 0, 0, 2, 0), 6, 1, 32'h55, 32'h8000_0044};
      tbl[9] = '{mk(32'h0000_2483, 1, 5'd9, 32'h1234, 0, 0, 32'hCAFE_0001, 3, 0),
                 9, 1, 32'hCAFE_0001, 32'h8000_0048};

      clear_inputs();
      rst_n = 1'b0;
      step(); step();
      chk("reset_pc", pc, RPC);
      chk("reset_if_req_valid", {31'd0, if_req_valid}, 1);
      chk("reset_halted", {31'd0, halted}, 0);
      chk("reset_bus_err", {31'd0, bus_err}, 0);
      chk("reset_retired", {31'd0, retired}, 0);
      chk("reset_rf_wen", {31'd0, rf_wen}, 0);
      chk("reset_mem_req_valid", {31'd0, mem_req_valid}, 0);
      chk("reset_inst", inst, 32'h0000_0013);
      rst_n = 1'b1;

      mpc = RPC;
      for (int i = 0; i < 10; i++) begin
         check_instr($sformatf("vec%0d", i), tbl[i].in, mpc, tbl[i].cyc, tbl[i].wen,
                     tbl[i].wdata, tbl[i].pc_after);
         mpc = tbl[i].pc_after;
      end

      // Random instruction stream; stalls stay below the timeout of 4.
      for (int i = 0; i < 30; i++) begin
         t = mk($urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                ($urandom_range(0, 3) == 0), $urandom & 32'hFFFF_FFFC, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3));
         model(t, mpc, cyc, wen, wd, pa);
         check_instr($sformatf("rnd%0d", i), t, mpc, cyc, wen, wd, pa);
         mpc = pa;
      end

      // Stop request: retire without writeback, then hold in HALT.
      t = mk(32'h0010_0073, 0, 5'd12, 32'h77, 1, 32'h8000_0800, 0, 0, 0);
      t.stop = 1'b1;
      model(t, mpc, cyc, wen, wd, pa);
      check_instr("stop", t, mpc, cyc, wen, wd, pa);
      chk("stop_halted", {31'd0, halted}, 1);
      chk("stop_bus_err", {31'd0, bus_err}, 0);
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         if_req_ready = 1; if_rsp_valid = 1; mem_req_ready = 1; mem_rsp_valid = 1;
         if (!halted || rf_wen || retired || if_req_valid || mem_req_valid || pc != mpc) bad++;
         step();
      end
      clear_inputs();
      $display("halt_hold: 100 cycles, violations=%0d", bad);
      chk("halt_hold_violations", bad, 0);

      // Fetch request never accepted: bus error after the 4th stalled cycle.
      do_reset();
      for (int i = 0; i < 4; i++) step();
      $display("timeout: halted=%0b bus_err=%0b", halted, bus_err);
      chk("timeout_halted", {31'd0, halted}, 1);
      chk("timeout_bus_err", {31'd0, bus_err}, 1);
      chk("timeout_if_req_valid", {31'd0, if_req_valid}, 0);

      // Ready on the 4th stalled cycle: exit wins over timeout.
      do_reset();
      for (int i = 0; i < 3; i++) step();
      chk("edge_not_halted_yet", {31'd0, halted}, 0);
      if_req_ready = 1;
      step();
      if_req_ready = 0;
      $display("timeout_edge: halted=%0b if_req_valid=%0b", halted, if_req_valid);
      chk("edge_halted", {31'd0, halted}, 0);
      chk("edge_in_if_wait", {31'd0, if_req_valid}, 0);
      if_rsp_valid = 1; if_rsp_inst = 32'h0000_2503;
      dec_memtoreg = 1; dec_rd = 5'd10; alu_result = 32'h8000_0200;
      step();
      if_rsp_valid = 0;
      step();
      chk("abort_mem_req_valid", {31'd0, mem_req_valid}, 1);
      chk("abort_mem_addr", mem_addr, 32'h8000_0200);
      mem_req_ready = 1;
      step();
      mem_req_ready = 0;
      step();
      rst_n = 1'b0;
      #1;
      $display("abort: pc=%h if_req_valid=%0b mem_req_valid=%0b inst=%h", pc, if_req_valid,
               mem_req_valid, inst);
      chk("abort_pc", pc, RPC);
      chk("abort_if_req_valid", {31'd0, if_req_valid}, 1);
      chk("abort_mem_req_valid_low", {31'd0, mem_req_valid}, 0);
      chk("abort_rf_wen", {31'd0, rf_wen}, 0);
      chk("abort_retired", {31'd0, retired}, 0);
      chk("abort_inst", inst, 32'h0000_0013);
      step();
      clear_inputs();
      rst_n = 1'b1;
      // Stale responses after release must be ignored.
      mem_rsp_valid = 1; mem_rsp_rdata = 32'hBAD0_BAD0;
      if_rsp_valid = 1; if_rsp_inst = 32'hFFFF_FFFF;
      step();
      clear_inputs();
      t = mk(32'h0330_0593, 0, 5'd11, 32'h33, 0, 0, 0, 0, 0);
      model(t, RPC, cyc, wen, wd, pa);
      check_instr("post_abort", t, RPC, cyc, wen, wd, pa);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
